// File: rtl/write_back_unit_if.sv
// Write-back stage bundle: instruction inputs from MEM/WB, register-file write port,
// decode bypass query/response and the retired-instruction count.
interface write_back_unit_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              valid_in;
  logic              stall;
  logic [2:0]        wb_sel;
  logic [REG_AW-1:0] rd_addr;
  logic [XLEN-1:0]   alu_result;
  logic [XLEN-1:0]   immediate;
  logic [XLEN-1:0]   mem_data;
  logic [XLEN-1:0]   pc_next;
  logic [REG_AW-1:0] fwd_rs1_addr;
  logic [REG_AW-1:0] fwd_rs2_addr;
  logic [XLEN-1:0]   write_data;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [XLEN-1:0]   rf_wdata;
  logic              fwd_rs1_hit;
  logic              fwd_rs2_hit;
  logic [31:0]       instret;

  modport master (
    output valid_in, stall, wb_sel, rd_addr, alu_result, immediate, mem_data,
           pc_next, fwd_rs1_addr, fwd_rs2_addr,
    input  write_data, rf_we, rf_waddr, rf_wdata, fwd_rs1_hit, fwd_rs2_hit, instret
  );

  modport slave (
    input  valid_in, stall, wb_sel, rd_addr, alu_result, immediate, mem_data,
           pc_next, fwd_rs1_addr, fwd_rs2_addr,
    output write_data, rf_we, rf_waddr, rf_wdata, fwd_rs1_hit, fwd_rs2_hit, instret
  );
endinterface

// File: rtl/write_back_unit.sv
// RISC-V write-back: combinational source mux and bypass hits, register-file write one cycle later.
// No backpressure; stall freezes every register (rf write port and instret).
module write_back_unit #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  write_back_unit_if.slave    wb
);

  typedef enum logic [2:0] {
    SEL_NONE = 3'b000,
    SEL_ALU  = 3'b100,
    SEL_IMM  = 3'b101,
    SEL_MEM  = 3'b110,
    SEL_PC   = 3'b111
  } wb_sel_t;

  logic [XLEN-1:0]   sel_data;
  logic              wr_req;
  logic              rf_we_q;
  logic [REG_AW-1:0] rf_waddr_q;
  logic [XLEN-1:0]   rf_wdata_q;
  logic [31:0]       instret_q;

  // Invalid codes 001..011 fall into the default and produce zero.
  always_comb begin
    sel_data = '0;
    case (wb.wb_sel)
      SEL_ALU: sel_data = wb.alu_result;
      SEL_IMM: sel_data = wb.immediate;
      SEL_MEM: sel_data = wb.mem_data;
      SEL_PC:  sel_data = wb.pc_next;
      default: sel_data = '0;
    endcase
  end

  assign wr_req = wb.valid_in && wb.wb_sel[2] && (wb.rd_addr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      instret_q  <= '0;
    end else if (!wb.stall) begin
      rf_we_q    <= wr_req;
      rf_waddr_q <= wb.rd_addr;
      rf_wdata_q <= sel_data;
      if (wb.valid_in)
        instret_q <= instret_q + 32'd1;
    end
  end

  assign wb.write_data  = sel_data;
  assign wb.fwd_rs1_hit = wr_req && (wb.fwd_rs1_addr == wb.rd_addr);
  assign wb.fwd_rs2_hit = wr_req && (wb.fwd_rs2_addr == wb.rd_addr);
  assign wb.rf_we       = rf_we_q;
  assign wb.rf_waddr    = rf_waddr_q;
  assign wb.rf_wdata    = rf_wdata_q;
  assign wb.instret     = instret_q;

endmodule

// File: tb/tb_write_back_unit.sv
// Directed bench for write_back_unit: source mux, x0/NONE suppression, bypass, stall, reset, wrap.
module tb_write_back_unit;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  logic [31:0] exp_instret;

  write_back_unit_if #(.XLEN(32), .REG_AW(5)) wbi ();

  write_back_unit #(.XLEN(32), .REG_AW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (wbi.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vld, input logic stl, input logic [2:0] sel,
                       input logic [4:0] rd);
    wbi.valid_in = vld;
    wbi.stall    = stl;
    wbi.wb_sel   = sel;
    wbi.rd_addr  = rd;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 3'b100, 5'd0);
    wbi.alu_result   = 32'hA5A5A5A5;
    wbi.immediate    = 32'h12345678;
    wbi.mem_data     = 32'hBBBBBBBB;
    wbi.pc_next      = 32'h00001000;
    wbi.fwd_rs1_addr = 5'd0;
    wbi.fwd_rs2_addr = 5'd0;
    #3;
    n_checks++;
    if (wbi.rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_rf_we got=%b exp=0", wbi.rf_we); end
    n_checks++;
    if (wbi.rf_waddr !== 5'd0) begin n_fail++; $display("FAIL reset_rf_waddr got=%0d exp=0", wbi.rf_waddr); end
    n_checks++;
    if (wbi.rf_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_rf_wdata got=%h exp=0", wbi.rf_wdata); end
    n_checks++;
    if (wbi.instret !== 32'h0) begin n_fail++; $display("FAIL reset_instret got=%h exp=0", wbi.instret); end
    // mux is live while reset is held
    n_checks++;
    if (wbi.write_data !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL reset_write_data got=%h exp=a5a5a5a5", wbi.write_data); end
    @(negedge clk);
    rst_n = 1'b1;
    exp_instret = 32'h0;
  endtask

  task automatic test_alu_write();
    drive(1'b1, 1'b0, 3'b100, 5'd5);
    #1;
    n_checks++;
    if (wbi.write_data !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL alu_write_data got=%h exp=a5a5a5a5", wbi.write_data); end
    step();
    exp_instret++;
    n_checks++;
    if (wbi.rf_we !== 1'b1) begin n_fail++; $display("FAIL alu_rf_we got=%b exp=1", wbi.rf_we); end
    n_checks++;
    if (wbi.rf_waddr !== 5'd5) begin n_fail++; $display("FAIL alu_rf_waddr got=%0d exp=5", wbi.rf_waddr); end
    n_checks++;
    if (wbi.rf_wdata !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL alu_rf_wdata got=%h exp=a5a5a5a5", wbi.rf_wdata); end
    n_checks++;
    if (wbi.instret !== exp_instret) begin n_fail++; $display("FAIL alu_instret got=%h exp=%h", wbi.instret, exp_instret); end
  endtask

  task automatic test_source_sweep();
    logic [2:0]  sels [5];
    logic [31:0] exps [5];
    logic        wes  [5];
    sels = '{3'b101, 3'b110, 3'b111, 3'b011, 3'b000};
    exps = '{32'h12345678, 32'hBBBBBBBB, 32'h00001000, 32'h0, 32'h0};
    wes  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, sels[i], 5'(i + 1));
      #1;
      n_checks++;
      if (wbi.write_data !== exps[i]) begin
        n_fail++; $display("FAIL sweep_write_data sel=%b got=%h exp=%h", sels[i], wbi.write_data, exps[i]);
      end
      step();
      exp_instret++;
      n_checks++;
      if (wbi.rf_we !== wes[i]) begin
        n_fail++; $display("FAIL sweep_rf_we sel=%b got=%b exp=%b", sels[i], wbi.rf_we, wes[i]);
      end
      n_checks++;
      if (wbi.rf_wdata !== exps[i]) begin
        n_fail++; $display("FAIL sweep_rf_wdata sel=%b got=%h exp=%h", sels[i], wbi.rf_wdata, exps[i]);
      end
      n_checks++;
      if (wbi.rf_waddr !== 5'(i + 1)) begin
        n_fail++; $display("FAIL sweep_rf_waddr sel=%b got=%0d exp=%0d", sels[i], wbi.rf_waddr, i + 1);
      end
    end
    n_checks++;
    if (wbi.instret !== exp_instret) begin n_fail++; $display("FAIL sweep_instret got=%h exp=%h", wbi.instret, exp_instret); end
  endtask

  task automatic test_x0_none();
    // x0 destination with a real source
    drive(1'b1, 1'b0, 3'b100, 5'd0);
    wbi.fwd_rs1_addr = 5'd0;
    wbi.fwd_rs2_addr = 5'd0;
    #1;
    n_checks++;
    if ({wbi.fwd_rs1_hit, wbi.fwd_rs2_hit} !== 2'b00) begin
      n_fail++; $display("FAIL x0_hits got=%b exp=00", {wbi.fwd_rs1_hit, wbi.fwd_rs2_hit});
    end
    step();
    exp_instret++;
    n_checks++;
    if (wbi.rf_we !== 1'b0) begin n_fail++; $display("FAIL x0_rf_we got=%b exp=0", wbi.rf_we); end
    n_checks++;
    if (wbi.instret !== exp_instret) begin n_fail++; $display("FAIL x0_instret got=%h exp=%h", wbi.instret, exp_instret); end
    // NONE select to a non-zero register
    drive(1'b1, 1'b0, 3'b000, 5'd3);
    wbi.fwd_rs1_addr = 5'd3;
    wbi.fwd_rs2_addr = 5'd3;
    #1;
    n_checks++;
    if ({wbi.fwd_rs1_hit, wbi.fwd_rs2_hit} !== 2'b00) begin
      n_fail++; $display("FAIL none_hits got=%b exp=00", {wbi.fwd_rs1_hit, wbi.fwd_rs2_hit});
    end
    step();
    exp_instret++;
    n_checks++;
    if (wbi.rf_we !== 1'b0) begin n_fail++; $display("FAIL none_rf_we got=%b exp=0", wbi.rf_we); end
    n_checks++;
    if (wbi.instret !== exp_instret) begin n_fail++; $display("FAIL none_instret got=%h exp=%h", wbi.instret, exp_instret); end
  endtask

  task automatic test_bypass();
    drive(1'b1, 1'b0, 3'b100, 5'd7);
    wbi.fwd_rs1_addr = 5'd7;
    wbi.fwd_rs2_addr = 5'd8;
    #1;
    n_checks++;
    if ({wbi.fwd_rs1_hit, wbi.fwd_rs2_hit} !== 2'b10) begin
      n_fail++; $display("FAIL bypass_valid got=%b exp=10", {wbi.fwd_rs1_hit, wbi.fwd_rs2_hit});
    end
    wbi.fwd_rs1_addr = 5'd8;
    wbi.fwd_rs2_addr = 5'd7;
    #1;
    n_checks++;
    if ({wbi.fwd_rs1_hit, wbi.fwd_rs2_hit} !== 2'b01) begin
      n_fail++; $display("FAIL bypass_rs2 got=%b exp=01", {wbi.fwd_rs1_hit, wbi.fwd_rs2_hit});
    end
    wbi.valid_in = 1'b0;
    wbi.fwd_rs1_addr = 5'd7;
    #1;
    n_checks++;
    if ({wbi.fwd_rs1_hit, wbi.fwd_rs2_hit} !== 2'b00) begin
      n_fail++; $display("FAIL bypass_invalid got=%b exp=00", {wbi.fwd_rs1_hit, wbi.fwd_rs2_hit});
    end
    n_checks++;
    if (wbi.write_data !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL bypass_invalid_mux got=%h exp=a5a5a5a5", wbi.write_data); end
  endtask

  task automatic test_stall();
    wbi.alu_result = 32'h11111111;
    drive(1'b1, 1'b0, 3'b100, 5'd9);
    step();
    exp_instret++;
    wbi.alu_result = 32'h22222222;
    drive(1'b1, 1'b1, 3'b100, 5'd10);
    step();
    n_checks++;
    if ({wbi.rf_we, wbi.rf_waddr, wbi.rf_wdata} !== {1'b1, 5'd9, 32'h11111111}) begin
      n_fail++; $display("FAIL stall_hold got=%b/%0d/%h exp=1/9/11111111", wbi.rf_we, wbi.rf_waddr, wbi.rf_wdata);
    end
    n_checks++;
    if (wbi.instret !== exp_instret) begin n_fail++; $display("FAIL stall_instret got=%h exp=%h", wbi.instret, exp_instret); end
    wbi.stall = 1'b0;
    step();
    exp_instret++;
    n_checks++;
    if ({wbi.rf_we, wbi.rf_waddr, wbi.rf_wdata} !== {1'b1, 5'd10, 32'h22222222}) begin
      n_fail++; $display("FAIL stall_release got=%b/%0d/%h exp=1/10/22222222", wbi.rf_we, wbi.rf_waddr, wbi.rf_wdata);
    end
    n_checks++;
    if (wbi.instret !== exp_instret) begin n_fail++; $display("FAIL stall_release_instret got=%h exp=%h", wbi.instret, exp_instret); end
  endtask

  task automatic test_reset_mid();
    wbi.alu_result = 32'h0000CAFE;
    drive(1'b1, 1'b0, 3'b100, 5'd4);
    while (exp_instret < 32'h10) begin
      step();
      exp_instret++;
    end
    n_checks++;
    if ({wbi.rf_we, wbi.instret} !== {1'b1, 32'h10}) begin
      n_fail++; $display("FAIL premid_state got=%b/%h exp=1/00000010", wbi.rf_we, wbi.instret);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({wbi.rf_we, wbi.rf_waddr, wbi.rf_wdata, wbi.instret} !== {1'b0, 5'd0, 32'h0, 32'h0}) begin
      n_fail++; $display("FAIL midreset_clear got=%b/%0d/%h/%h exp=0/0/0/0",
                         wbi.rf_we, wbi.rf_waddr, wbi.rf_wdata, wbi.instret);
    end
    n_checks++;
    if (wbi.fwd_rs1_hit !== 1'b0 || wbi.write_data !== 32'h0000CAFE) begin
      n_fail++; $display("FAIL midreset_comb got=%b/%h exp=0/0000cafe", wbi.fwd_rs1_hit, wbi.write_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_instret = 32'h0;
  endtask

  task automatic test_wrap();
    drive(1'b0, 1'b0, 3'b000, 5'd0);
    @(negedge clk);
    force dut.instret_q = 32'hFFFFFFFF;
    #1;
    release dut.instret_q;
    #1;
    n_checks++;
    if (wbi.instret !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL wrap_preload got=%h exp=ffffffff", wbi.instret); end
    drive(1'b1, 1'b0, 3'b000, 5'd0);
    step();
    n_checks++;
    if (wbi.instret !== 32'h0) begin n_fail++; $display("FAIL wrap_instret got=%h exp=0", wbi.instret); end
    drive(1'b1, 1'b1, 3'b000, 5'd0);
    step();
    n_checks++;
    if (wbi.instret !== 32'h0) begin n_fail++; $display("FAIL stall_valid_instret got=%h exp=0", wbi.instret); end
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    exp_instret = 32'h0;
    test_reset();
    test_alu_write();
    test_source_sweep();
    test_x0_none();
    test_bypass();
    test_stall();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
